// File: rtl/rv32_muldiv_wb_arbiter.sv
// Writeback-slot arbiter for the out-of-band mul/div unit: buffers completions in a
// small FIFO and injects them into free writeback slots, stealing one when the head starves.
module rv32_muldiv_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pipe_valid_i,
    input  logic                       pipe_reg_write_i,
    input  logic [1:0]                 pipe_result_source_i,
    input  logic                       md_valid_i,
    output logic                       md_ready_o,
    input  logic [31:0]                md_instr_i,
    input  logic [31:0]                md_result_i,
    output logic                       instr_source_o,
    output logic [1:0]                 result_source_o,
    output logic [31:0]                muldiv_instr_o,
    output logic [31:0]                mul_div_result_o,
    output logic                       reg_write_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     pending_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(STARVE_MAX);

    logic [31:0]   instr_mem  [DEPTH];
    logic [31:0]   result_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;

    logic slot_busy;
    logic not_empty;
    logic push;
    logic pop;
    logic stall;

    assign slot_busy  = pipe_valid_i && pipe_reg_write_i;
    assign not_empty  = (count != '0);
    // Acceptance deliberately ignores a same-cycle pop to keep md_ready off the pipeline path.
    assign md_ready_o = (count != FULL_CNT);
    assign push       = md_valid_i && md_ready_o;
    assign stall      = not_empty && slot_busy && (wait_cnt == WAIT_LIM);
    assign pop        = not_empty && (!slot_busy || stall);

    assign stall_o          = stall;
    assign pending_o        = count;
    assign muldiv_instr_o   = instr_mem[rd_ptr];
    assign mul_div_result_o = result_mem[rd_ptr];

    always_comb begin
        instr_source_o  = 1'b0;
        result_source_o = pipe_result_source_i;
        reg_write_o     = slot_busy;
        if (pop) begin
            instr_source_o  = 1'b1;
            result_source_o = 2'b11;
            reg_write_o     = 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr]  <= md_instr_i;
            result_mem[wr_ptr] <= md_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop || !not_empty) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_wb_arbiter.sv
// Directed bench for rv32_muldiv_wb_arbiter with a scoreboard queue of accepted
// completions that is checked against every injected writeback.
module tb_rv32_muldiv_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i;
    logic        pipe_reg_write_i;
    logic [1:0]  pipe_result_source_i;
    logic        md_valid_i;
    logic        md_ready_o;
    logic [31:0] md_instr_i;
    logic [31:0] md_result_i;
    logic        instr_source_o;
    logic [1:0]  result_source_o;
    logic [31:0] muldiv_instr_o;
    logic [31:0] mul_div_result_o;
    logic        reg_write_o;
    logic        stall_o;
    logic [1:0]  pending_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    rv32_muldiv_wb_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .pipe_valid_i         (pipe_valid_i),
        .pipe_reg_write_i     (pipe_reg_write_i),
        .pipe_result_source_i (pipe_result_source_i),
        .md_valid_i           (md_valid_i),
        .md_ready_o           (md_ready_o),
        .md_instr_i           (md_instr_i),
        .md_result_i          (md_result_i),
        .instr_source_o       (instr_source_o),
        .result_source_o      (result_source_o),
        .muldiv_instr_o       (muldiv_instr_o),
        .mul_div_result_o     (mul_div_result_o),
        .reg_write_o          (reg_write_o),
        .stall_o              (stall_o),
        .pending_o            (pending_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the negedge: scores any retiring entry, records any accepted push,
    // then advances through the next rising edge.
    task automatic cyc();
        logic [63:0] head;
        if (instr_source_o === 1'b1) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                head = sb_q.pop_front();
                check("sb_instr", muldiv_instr_o, head[63:32]);
                check("sb_result", mul_div_result_o, head[31:0]);
                check("sb_rsel", 32'(result_source_o), 32'd3);
                check("sb_we", 32'(reg_write_o), 32'd1);
                $display("retire instr=%h result=%h stall=%0d", muldiv_instr_o, mul_div_result_o, stall_o);
            end
        end
        if (md_valid_i && md_ready_o) begin
            sb_q.push_back({md_instr_i, md_result_i});
            $display("accept instr=%h result=%h", md_instr_i, md_result_i);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic slot(input logic busy, input logic [1:0] rsel);
        pipe_valid_i         = busy;
        pipe_reg_write_i     = busy;
        pipe_result_source_i = rsel;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] res);
        md_valid_i  = v;
        md_instr_i  = ins;
        md_result_i = res;
    endtask

    initial begin
        rst_i = 1'b1;
        slot(1'b0, 2'b01);
        offer(1'b0, 32'h0, 32'h0);

        // Reset state
        @(negedge clk_i);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_ready", 32'(md_ready_o), 32'd1);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_isrc", 32'(instr_source_o), 32'd0);
        check("rst_rsel", 32'(result_source_o), 32'd1);
        check("rst_we", 32'(reg_write_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        slot(1'b0, 2'b00);

        // Single push, idle slot: retires the next cycle
        offer(1'b1, 32'h02B50533, 32'h000000F0);
        @(negedge clk_i);
        check("p1_ready", 32'(md_ready_o), 32'd1);
        check("p1_no_bypass", 32'(instr_source_o), 32'd0);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("p1_isrc", 32'(instr_source_o), 32'd1);
        check("p1_rsel", 32'(result_source_o), 32'd3);
        check("p1_we", 32'(reg_write_o), 32'd1);
        check("p1_result", mul_div_result_o, 32'h000000F0);
        cyc();
        @(negedge clk_i);
        check("p1_pending0", 32'(pending_o), 32'd0);
        check("p1_isrc0", 32'(instr_source_o), 32'd0);
        cyc();

        // Starvation: busy slot for STARVE_MAX cycles, then a stolen slot
        slot(1'b1, 2'b10);
        offer(1'b1, 32'h02C5C5B3, 32'h12345678);
        @(negedge clk_i);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            check($sformatf("starve_nostall_%0d", k), 32'(stall_o), 32'd0);
            check($sformatf("starve_isrc_%0d", k), 32'(instr_source_o), 32'd0);
            check($sformatf("starve_rsel_%0d", k), 32'(result_source_o), 32'd2);
            check($sformatf("starve_we_%0d", k), 32'(reg_write_o), 32'd1);
            cyc();
        end
        @(negedge clk_i);
        check("starve_stall", 32'(stall_o), 32'd1);
        check("starve_isrc", 32'(instr_source_o), 32'd1);
        cyc();
        @(negedge clk_i);
        check("starve_after_stall", 32'(stall_o), 32'd0);
        check("starve_after_pending", 32'(pending_o), 32'd0);
        check("starve_after_rsel", 32'(result_source_o), 32'd2);
        cyc();

        // Three back-to-back completions into a DEPTH=2 FIFO behind a busy slot
        slot(1'b1, 2'b00);
        offer(1'b1, 32'h03000033, 32'hA0000001);
        @(negedge clk_i);
        check("bb_ready1", 32'(md_ready_o), 32'd1);
        cyc();
        offer(1'b1, 32'h03100033, 32'hA0000002);
        @(negedge clk_i);
        check("bb_ready2", 32'(md_ready_o), 32'd1);
        check("bb_pending1", 32'(pending_o), 32'd1);
        cyc();
        offer(1'b1, 32'h03200033, 32'hA0000003);
        @(negedge clk_i);
        check("bb_ready3", 32'(md_ready_o), 32'd0);
        check("bb_pending2", 32'(pending_o), 32'd2);
        check("bb_hold", 32'(instr_source_o), 32'd0);
        cyc();
        slot(1'b0, 2'b00);
        @(negedge clk_i);
        check("bb_pop1", 32'(instr_source_o), 32'd1);
        check("bb_full_ready", 32'(md_ready_o), 32'd0);
        cyc();
        @(negedge clk_i);
        check("bb_third_ready", 32'(md_ready_o), 32'd1);
        check("bb_third_pending", 32'(pending_o), 32'd1);
        check("bb_pop2", 32'(instr_source_o), 32'd1);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("bb_pop3", 32'(instr_source_o), 32'd1);
        cyc();
        @(negedge clk_i);
        check("bb_drained", 32'(pending_o), 32'd0);
        cyc();

        // Continuous streaming with an idle slot, across pointer wrap
        for (int i = 0; i < 6; i++) begin
            offer(1'b1, 32'h02000033 + 32'(i << 7), 32'h1111 * 32'(i + 1));
            @(negedge clk_i);
            check($sformatf("stream_ready_%0d", i), 32'(md_ready_o), 32'd1);
            if (i > 0) begin
                check($sformatf("stream_pending_%0d", i), 32'(pending_o), 32'd1);
                check($sformatf("stream_isrc_%0d", i), 32'(instr_source_o), 32'd1);
            end
            cyc();
        end
        offer(1'b0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("stream_last_pop", 32'(instr_source_o), 32'd1);
        cyc();
        @(negedge clk_i);
        check("stream_drained", 32'(pending_o), 32'd0);
        cyc();

        // Asynchronous reset with two entries pending
        slot(1'b1, 2'b00);
        offer(1'b1, 32'h0DEAD033, 32'hDEADBEEF);
        @(negedge clk_i);
        cyc();
        offer(1'b1, 32'h0BEEF033, 32'hCAFEF00D);
        @(negedge clk_i);
        cyc();
        offer(1'b0, 32'h0, 32'h0);
        check("ar_pre_pending", 32'(pending_o), 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_pending", 32'(pending_o), 32'd0);
        check("ar_ready", 32'(md_ready_o), 32'd1);
        check("ar_isrc", 32'(instr_source_o), 32'd0);
        sb_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        slot(1'b0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check($sformatf("ar_nostale_%0d", k), 32'(instr_source_o), 32'd0);
            check($sformatf("ar_empty_%0d", k), 32'(pending_o), 32'd0);
            cyc();
        end

        // Idle slot, empty FIFO: pure pass-through
        slot(1'b0, 2'b01);
        @(negedge clk_i);
        check("idle_rsel", 32'(result_source_o), 32'd1);
        check("idle_isrc", 32'(instr_source_o), 32'd0);
        check("idle_we", 32'(reg_write_o), 32'd0);
        check("idle_stall", 32'(stall_o), 32'd0);
        cyc();

        check("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
